// File: rtl/uart_pkg.sv
// uart_pkg: definitions shared by the UART transmit FIFO block.
//   DATA_W        - byte width carried through the FIFO
//   DEFAULT_DEPTH - default FIFO depth (power of two)
//   tx_state_t    - launch FSM encoding (IDLE / LAUNCH / SEND)
package uart_pkg;

  localparam int DATA_W        = 8;
  localparam int DEFAULT_DEPTH = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LAUNCH = 2'd1,
    SEND   = 2'd2
  } tx_state_t;

endpackage

// File: rtl/uart_tx_fifo_if.sv
// uart_tx_fifo_if: host push side plus transmitter handshake of uart_tx_fifo.
//   master : host / transmitter side (drives wr_en, wr_data, tx_busy)
//   slave  : the FIFO block (drives full, empty, count, tx_start, tx_data)
// Optional macro UART_TX_FIFO_OVF_EN adds overflow (slave out) and
// ovf_clr (master out).
interface uart_tx_fifo_if #(
  parameter int ADDR_W = 4
) ();

  logic                        wr_en;
  logic [uart_pkg::DATA_W-1:0] wr_data;
  logic                        full;
  logic                        empty;
  logic [ADDR_W:0]             count;
  logic                        tx_start;
  logic [uart_pkg::DATA_W-1:0] tx_data;
  logic                        tx_busy;
`ifdef UART_TX_FIFO_OVF_EN
  logic                        overflow;
  logic                        ovf_clr;

  modport master (
    output wr_en, wr_data, tx_busy, ovf_clr,
    input  full, empty, count, tx_start, tx_data, overflow
  );

  modport slave (
    input  wr_en, wr_data, tx_busy, ovf_clr,
    output full, empty, count, tx_start, tx_data, overflow
  );
`else
  modport master (
    output wr_en, wr_data, tx_busy,
    input  full, empty, count, tx_start, tx_data
  );

  modport slave (
    input  wr_en, wr_data, tx_busy,
    output full, empty, count, tx_start, tx_data
  );
`endif

endinterface

// File: rtl/uart_tx_fifo_sync_fifo.sv
// sync_fifo: single-clock byte FIFO with registered occupancy and flags.
//   clk, rst  - clock, synchronous active-high reset
//   i_push    - push request (ignored while full)
//   i_data    - byte to push
//   i_pop     - pop request (ignored while empty)
//   o_head    - byte at the read pointer
//   o_full    - occupancy == DEPTH
//   o_empty   - occupancy == 0
//   o_count   - occupancy 0..DEPTH
module sync_fifo #(
  parameter int DEPTH  = uart_pkg::DEFAULT_DEPTH,
  parameter int ADDR_W = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        i_push,
  input  logic [uart_pkg::DATA_W-1:0] i_data,
  input  logic                        i_pop,
  output logic [uart_pkg::DATA_W-1:0] o_head,
  output logic                        o_full,
  output logic                        o_empty,
  output logic [ADDR_W:0]             o_count
);
  import uart_pkg::*;

  localparam logic [ADDR_W:0]   L_FULL_CNT = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W:0]   L_CNT_ONE  = (ADDR_W + 1)'(1);
  localparam logic [ADDR_W:0]   L_CNT_ZERO = (ADDR_W + 1)'(0);
  localparam logic [ADDR_W-1:0] L_PTR_ONE  = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] L_PTR_ZERO = ADDR_W'(0);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [ADDR_W-1:0] r_wr_ptr;
  logic [ADDR_W-1:0] r_rd_ptr;
  logic [ADDR_W:0]   r_count;
  logic              r_full;
  logic              r_empty;
  logic [ADDR_W:0]   w_count_nxt;
  logic              w_push_ok;
  logic              w_pop_ok;

  // Push is gated by the registered full flag, so a push while full is
  // dropped even when a pop frees a slot in the same cycle.
  assign w_push_ok = i_push && !r_full;
  assign w_pop_ok  = i_pop && !r_empty;

  // Next occupancy: a simultaneous push and pop leaves the count unchanged.
  always_comb begin
    w_count_nxt = r_count;
    case ({w_push_ok, w_pop_ok})
      2'b10:   w_count_nxt = r_count + L_CNT_ONE;
      2'b01:   w_count_nxt = r_count - L_CNT_ONE;
      default: w_count_nxt = r_count;
    endcase
  end

  // Storage array write port (contents need no reset).
  always_ff @(posedge clk) begin
    if (w_push_ok) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  // Pointers, occupancy and flags; pointers wrap naturally at DEPTH.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= L_PTR_ZERO;
      r_rd_ptr <= L_PTR_ZERO;
      r_count  <= L_CNT_ZERO;
      r_full   <= 1'b0;
      r_empty  <= 1'b1;
    end else begin
      if (w_push_ok) begin
        r_wr_ptr <= r_wr_ptr + L_PTR_ONE;
      end
      if (w_pop_ok) begin
        r_rd_ptr <= r_rd_ptr + L_PTR_ONE;
      end
      r_count <= w_count_nxt;
      r_full  <= (w_count_nxt == L_FULL_CNT);
      r_empty <= (w_count_nxt == L_CNT_ZERO);
    end
  end

  assign o_head  = r_mem[r_rd_ptr];
  assign o_full  = r_full;
  assign o_empty = r_empty;
  assign o_count = r_count;

endmodule

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: byte queue in front of a UART transmitter.
//   clk - system clock, rising edge
//   rst - synchronous active-high reset
//   bus - uart_tx_fifo_if.slave: wr_en/wr_data push side, full/empty/count
//         status, tx_start/tx_data/tx_busy transmitter handshake
// Optional macro UART_TX_FIFO_OVF_EN: adds a sticky overflow flag (bus.overflow)
// set by a push while full and cleared by bus.ovf_clr (set wins).
module uart_tx_fifo #(
  parameter int DEPTH  = uart_pkg::DEFAULT_DEPTH,
  parameter int ADDR_W = 4
) (
  input  logic           clk,
  input  logic           rst,
  uart_tx_fifo_if.slave  bus
);
  import uart_pkg::*;

  tx_state_t         r_state;
  logic              r_tx_start;
  logic [DATA_W-1:0] r_tx_data;
  logic [DATA_W-1:0] w_head;
  logic              w_full;
  logic              w_empty;
  logic [ADDR_W:0]   w_count;
  logic              w_pop;

  // The only pop point is the IDLE->LAUNCH transition.
  assign w_pop = (r_state == IDLE) && !w_empty && !bus.tx_busy;

  sync_fifo #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (bus.wr_en),
    .i_data  (bus.wr_data),
    .i_pop   (w_pop),
    .o_head  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  // Launch FSM: tx_start is a level request held until busy is seen, and
  // tx_data stays frozen from launch until the next pop.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_tx_start <= 1'b0;
      r_tx_data  <= {DATA_W{1'b0}};
    end else begin
      case (r_state)
        IDLE: begin
          if (w_pop) begin
            r_tx_data  <= w_head;
            r_tx_start <= 1'b1;
            r_state    <= LAUNCH;
          end else begin
            r_tx_start <= 1'b0;
          end
        end
        LAUNCH: begin
          if (bus.tx_busy) begin
            r_tx_start <= 1'b0;
            r_state    <= SEND;
          end else begin
            r_tx_start <= 1'b1;
          end
        end
        SEND: begin
          r_tx_start <= 1'b0;
          if (!bus.tx_busy) begin
            r_state <= IDLE;
          end else begin
            r_state <= SEND;
          end
        end
        default: begin
          r_tx_start <= 1'b0;
          r_state    <= IDLE;
        end
      endcase
    end
  end

  assign bus.full     = w_full;
  assign bus.empty    = w_empty;
  assign bus.count    = w_count;
  assign bus.tx_start = r_tx_start;
  assign bus.tx_data  = r_tx_data;

`ifdef UART_TX_FIFO_OVF_EN
  logic r_overflow;

  // Sticky overflow flag; a new overflow outranks a simultaneous clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_overflow <= 1'b0;
    end else if (bus.wr_en && w_full) begin
      r_overflow <= 1'b1;
    end else if (bus.ovf_clr) begin
      r_overflow <= 1'b0;
    end else begin
      r_overflow <= r_overflow;
    end
  end

  assign bus.overflow = r_overflow;
`endif

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: directed, self-checking bench for uart_tx_fifo.
// A vector table covers reset and the single-byte launch; hand-written
// sequences cover burst ordering, the full boundary, simultaneous push/pop
// across the pointer wrap and reset in the middle of a frame.
module tb_uart_tx_fifo;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  uart_tx_fifo_if #(.ADDR_W(4)) bus ();

  uart_tx_fifo #(
    .DEPTH  (16),
    .ADDR_W (4)
  ) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic       wr_en;
    logic [7:0] wr_data;
    logic       tx_busy;
    logic       exp_start;
    logic [7:0] exp_data;
    logic [4:0] exp_count;
    logic       exp_empty;
    logic       exp_full;
  } vec_t;

  vec_t vecs [11];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  // One transmitter frame: wait for the request, take it, hold busy, release.
  // cyc counts cycles since the previous busy release.
  task automatic xmit_frame(input logic [7:0] exp, input bit chk_gap, input string tag);
    int cyc;
    cyc = 0;
    while (bus.tx_start !== 1'b1 && cyc < 40) begin
      tick();
      cyc++;
    end
    check({tag, " start"}, {31'd0, bus.tx_start}, 32'd1);
    check({tag, " data"}, {24'd0, bus.tx_data}, {24'd0, exp});
    if (chk_gap) check({tag, " gap"}, cyc, 32'd2);
    bus.tx_busy = 1'b1;
    tick();
    check({tag, " drop"}, {31'd0, bus.tx_start}, 32'd0);
    tick();
    tick();
    check({tag, " hold"}, {24'd0, bus.tx_data}, {24'd0, exp});
    bus.tx_busy = 1'b0;
  endtask

  task automatic settle_idle(input string tag);
    tick();
    tick();
    tick();
    check({tag, " empty"}, {31'd0, bus.empty}, 32'd1);
    check({tag, " count"}, {27'd0, bus.count}, 32'd0);
    check({tag, " start"}, {31'd0, bus.tx_start}, 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin
    total = 0;
    bad   = 0;
    rst         = 1'b1;
    bus.wr_en   = 1'b0;
    bus.wr_data = 8'h00;
    bus.tx_busy = 1'b0;
`ifdef UART_TX_FIFO_OVF_EN
    bus.ovf_clr = 1'b0;
`endif

    //             rst   wr    data   busy   start data   cnt    empty full
    vecs[0]  = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 5'd0, 1'b1, 1'b0};
    vecs[1]  = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 5'd0, 1'b1, 1'b0};
    vecs[2]  = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 5'd0, 1'b1, 1'b0};
    vecs[3]  = '{1'b0, 1'b1, 8'hA5, 1'b0, 1'b0, 8'h00, 5'd1, 1'b0, 1'b0};
    vecs[4]  = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 8'hA5, 5'd0, 1'b1, 1'b0};
    vecs[5]  = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 8'hA5, 5'd0, 1'b1, 1'b0};
    vecs[6]  = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 8'hA5, 5'd0, 1'b1, 1'b0};
    vecs[7]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'hA5, 5'd0, 1'b1, 1'b0};
    vecs[8]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'hA5, 5'd0, 1'b1, 1'b0};
    vecs[9]  = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'hA5, 5'd0, 1'b1, 1'b0};
    vecs[10] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'hA5, 5'd0, 1'b1, 1'b0};

    // Reset and single-byte launch from the table.
    for (int i = 0; i < 11; i++) begin
      rst         = vecs[i].rst;
      bus.wr_en   = vecs[i].wr_en;
      bus.wr_data = vecs[i].wr_data;
      bus.tx_busy = vecs[i].tx_busy;
      tick();
      check($sformatf("vec%0d start", i), {31'd0, bus.tx_start}, {31'd0, vecs[i].exp_start});
      check($sformatf("vec%0d data", i), {24'd0, bus.tx_data}, {24'd0, vecs[i].exp_data});
      check($sformatf("vec%0d count", i), {27'd0, bus.count}, {27'd0, vecs[i].exp_count});
      check($sformatf("vec%0d empty", i), {31'd0, bus.empty}, {31'd0, vecs[i].exp_empty});
      check($sformatf("vec%0d full", i), {31'd0, bus.full}, {31'd0, vecs[i].exp_full});
    end
    bus.wr_en   = 1'b0;
    bus.tx_busy = 1'b0;
`ifdef UART_TX_FIFO_OVF_EN
    check("reset overflow", {31'd0, bus.overflow}, 32'd0);
`endif

    // Burst of five bytes: order and two-cycle restart after busy falls.
    for (int i = 1; i <= 5; i++) begin
      bus.wr_en   = 1'b1;
      bus.wr_data = 8'(i);
      tick();
    end
    bus.wr_en = 1'b0;
    check("burst count", {27'd0, bus.count}, 32'd4);
    for (int i = 1; i <= 5; i++) begin
      xmit_frame(8'(i), i != 1, $sformatf("burst%0d", i));
    end
    settle_idle("burst end");

    // Full boundary: busy held, 17 pushes, the 17th is dropped.
    bus.tx_busy = 1'b1;
    tick();
    for (int i = 0; i < 16; i++) begin
      bus.wr_en   = 1'b1;
      bus.wr_data = 8'h10 + 8'(i);
      tick();
    end
    check("full count16", {27'd0, bus.count}, 32'd16);
    check("full flag", {31'd0, bus.full}, 32'd1);
    bus.wr_data = 8'h20;
    tick();
    bus.wr_en = 1'b0;
    check("full drop count", {27'd0, bus.count}, 32'd16);
    check("full drop flag", {31'd0, bus.full}, 32'd1);
`ifdef UART_TX_FIFO_OVF_EN
    check("ovf set", {31'd0, bus.overflow}, 32'd1);
    tick();
    check("ovf sticky", {31'd0, bus.overflow}, 32'd1);
    bus.wr_en   = 1'b1;
    bus.ovf_clr = 1'b1;
    tick();
    check("ovf set wins", {31'd0, bus.overflow}, 32'd1);
    bus.wr_en = 1'b0;
    tick();
    check("ovf clear", {31'd0, bus.overflow}, 32'd0);
    bus.ovf_clr = 1'b0;
`endif
    bus.tx_busy = 1'b0;
    for (int i = 0; i < 16; i++) begin
      xmit_frame(8'h10 + 8'(i), i != 0, $sformatf("drain%0d", i));
    end
    settle_idle("full end");

    // Filler traffic to bring both pointers to index 14.
    bus.tx_busy = 1'b1;
    tick();
    for (int i = 0; i < 8; i++) begin
      bus.wr_en   = 1'b1;
      bus.wr_data = 8'h30 + 8'(i);
      tick();
    end
    bus.wr_en   = 1'b0;
    bus.tx_busy = 1'b0;
    for (int i = 0; i < 8; i++) begin
      xmit_frame(8'h30 + 8'(i), i != 0, $sformatf("fill%0d", i));
    end
    settle_idle("fill end");

    // Simultaneous push and pop with count 3, straddling the pointer wrap.
    bus.tx_busy = 1'b1;
    tick();
    for (int i = 0; i < 3; i++) begin
      bus.wr_en   = 1'b1;
      bus.wr_data = 8'hA0 + 8'(i);
      tick();
    end
    check("simul pre count", {27'd0, bus.count}, 32'd3);
    bus.wr_data = 8'hA3;
    bus.tx_busy = 1'b0;
    tick();
    bus.wr_en = 1'b0;
    check("simul count", {27'd0, bus.count}, 32'd3);
    check("simul start", {31'd0, bus.tx_start}, 32'd1);
    check("simul data", {24'd0, bus.tx_data}, 32'hA0);
    for (int i = 0; i < 4; i++) begin
      xmit_frame(8'hA0 + 8'(i), i != 0, $sformatf("simul%0d", i));
    end
    settle_idle("simul end");

    // Reset during SEND with four bytes queued.
    for (int i = 0; i < 5; i++) begin
      bus.wr_en   = 1'b1;
      bus.wr_data = 8'hB0 + 8'(i);
      tick();
    end
    bus.wr_en   = 1'b0;
    bus.tx_busy = 1'b1;
    tick();
    check("mid send start", {31'd0, bus.tx_start}, 32'd0);
    check("mid send count", {27'd0, bus.count}, 32'd4);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mid rst count", {27'd0, bus.count}, 32'd0);
    check("mid rst empty", {31'd0, bus.empty}, 32'd1);
    check("mid rst data", {24'd0, bus.tx_data}, 32'h00);
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("mid quiet%0d", i), {31'd0, bus.tx_start}, 32'd0);
    end
    bus.wr_en   = 1'b1;
    bus.wr_data = 8'hC0;
    tick();
    bus.wr_en = 1'b0;
    check("mid push count", {27'd0, bus.count}, 32'd1);
    for (int i = 0; i < 2; i++) begin
      tick();
      check($sformatf("mid busy wait%0d", i), {31'd0, bus.tx_start}, 32'd0);
    end
    bus.tx_busy = 1'b0;
    tick();
    check("mid relaunch start", {31'd0, bus.tx_start}, 32'd1);
    check("mid relaunch data", {24'd0, bus.tx_data}, 32'hC0);
    xmit_frame(8'hC0, 1'b0, "mid frame");
    settle_idle("mid end");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
